// File: rtl/csr_access_unit.sv
// CSR instruction sequencer: runs CSR read-modify-write ops, ECALL trap entry and MRET
// against an external CSR file, then issues the fetch redirect for traps/returns.
module csr_access_unit #(
    parameter int unsigned data_width     = 32,
    parameter int unsigned csr_addr_width = 12,
    parameter int unsigned csr_num        = 900
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [csr_addr_width-1:0] req_addr,
    input  logic [data_width-1:0]     req_operand,
    input  logic [data_width-1:0]     req_pc,
    output logic                      rsp_valid,
    output logic [data_width-1:0]     rsp_data,
    output logic                      rsp_err,
    output logic                      redir_valid,
    output logic [data_width-1:0]     redir_pc,
    output logic                      csr_we,
    output logic [csr_addr_width-1:0] csr_addr_w,
    output logic [csr_addr_width-1:0] csr_addr_r,
    output logic [data_width-1:0]     csr_wdata,
    input  logic [data_width-1:0]     csr_rdata,
    input  logic [data_width-1:0]     csr_mtvec,
    input  logic [data_width-1:0]     csr_mepc
);

    localparam logic [2:0] OP_ECALL = 3'b000;
    localparam logic [2:0] OP_MRET  = 3'b100;

    localparam logic [csr_addr_width-1:0] ADDR_MSTATUS = csr_addr_width'(12'h300);
    localparam logic [csr_addr_width-1:0] ADDR_MEPC    = csr_addr_width'(12'h341);
    localparam logic [csr_addr_width-1:0] ADDR_MCAUSE  = csr_addr_width'(12'h342);
    localparam logic [data_width-1:0]     CAUSE_ECALL  = data_width'(11);

    typedef enum logic [2:0] {
        IDLE, READ, WRITE, T_EPC, T_CAUSE, T_STAT, M_STAT, REDIR
    } state_t;

    state_t                      state, next_state;
    logic [2:0]                  op_q;
    logic [csr_addr_width-1:0]   addr_q;
    logic [data_width-1:0]       operand_q;
    logic [data_width-1:0]       pc_q;
    logic [data_width-1:0]       old_q;
    logic                        accept;
    logic                        is_imm;
    logic                        addr_illegal;
    logic                        set_clr_noop;
    logic [data_width-1:0]       rmw_value;
    logic [data_width-1:0]       status_new;

    assign accept       = (state == IDLE) && req_valid;
    assign is_imm       = req_op[2] && (req_op[1:0] != 2'b00);
    assign addr_illegal = 32'(addr_q) >= csr_num;
    // Set/clear with a zero mask is a pure read: the CSR must not see a write.
    assign set_clr_noop = op_q[1] && (operand_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_op == OP_ECALL) begin
                        next_state = T_EPC;
                    end else if (req_op == OP_MRET) begin
                        next_state = M_STAT;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = WRITE;
            WRITE:   next_state = IDLE;
            T_EPC:   next_state = T_CAUSE;
            T_CAUSE: next_state = T_STAT;
            T_STAT:  next_state = REDIR;
            M_STAT:  next_state = REDIR;
            REDIR:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture; immediate forms keep only the zero-extended zimm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 3'b000;
            addr_q    <= '0;
            operand_q <= '0;
            pc_q      <= '0;
            old_q     <= '0;
        end else begin
            if (accept) begin
                op_q      <= req_op;
                addr_q    <= req_addr;
                operand_q <= is_imm ? data_width'(req_operand[4:0]) : req_operand;
                pc_q      <= req_pc;
            end
            if (state == READ) begin
                old_q <= csr_rdata;
            end
        end
    end

    always_comb begin
        case (op_q[1:0])
            2'b10:   rmw_value = old_q | operand_q;
            2'b11:   rmw_value = old_q & ~operand_q;
            default: rmw_value = operand_q;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_err     = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        csr_we      = 1'b0;
        csr_addr_w  = '0;
        csr_addr_r  = '0;
        csr_wdata   = '0;
        status_new  = csr_rdata;
        case (state)
            IDLE: req_ready = 1'b1;
            READ: csr_addr_r = addr_q;
            WRITE: begin
                rsp_valid = 1'b1;
                if (addr_illegal) begin
                    rsp_err = 1'b1;
                end else begin
                    rsp_data = old_q;
                    if (!set_clr_noop) begin
                        csr_we     = 1'b1;
                        csr_addr_w = addr_q;
                        csr_wdata  = rmw_value;
                    end
                end
            end
            T_EPC: begin
                csr_we     = 1'b1;
                csr_addr_w = ADDR_MEPC;
                csr_wdata  = pc_q;
            end
            T_CAUSE: begin
                csr_we     = 1'b1;
                csr_addr_w = ADDR_MCAUSE;
                csr_wdata  = CAUSE_ECALL;
            end
            T_STAT: begin
                csr_addr_r        = ADDR_MSTATUS;
                status_new[7]     = csr_rdata[3];
                status_new[3]     = 1'b0;
                status_new[12:11] = 2'b11;
                csr_we            = 1'b1;
                csr_addr_w        = ADDR_MSTATUS;
                csr_wdata         = status_new;
            end
            M_STAT: begin
                csr_addr_r        = ADDR_MSTATUS;
                status_new[3]     = csr_rdata[7];
                status_new[7]     = 1'b1;
                status_new[12:11] = 2'b11;
                csr_we            = 1'b1;
                csr_addr_w        = ADDR_MSTATUS;
                csr_wdata         = status_new;
            end
            REDIR: begin
                redir_valid = 1'b1;
                redir_pc    = (op_q == OP_ECALL) ? {csr_mtvec[data_width-1:2], 2'b00} : csr_mepc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed vector table, trap/return and reset-abort sequences,
// and randomized ops checked cycle-by-cycle against a transaction-level CSR model.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_operand;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        csr_we;
    logic [11:0] csr_addr_w;
    logic [11:0] csr_addr_r;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;

    logic [31:0] mem   [4096];
    logic [31:0] model [4096];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign csr_rdata = mem[csr_addr_r];
    assign csr_mtvec = mem[12'h305];
    assign csr_mepc  = mem[12'h341];

    csr_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_operand(req_operand), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .csr_we(csr_we), .csr_addr_w(csr_addr_w), .csr_addr_r(csr_addr_r),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc)
    );

    typedef struct packed {
        logic        ready;
        logic        we;
        logic [11:0] aw;
        logic [11:0] ar;
        logic [31:0] wd;
        logic        rv;
        logic [31:0] rd;
        logic        re;
        logic        dv;
        logic [31:0] dpc;
    } obs_t;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] operand;
        logic [31:0] init;
        logic [31:0] e_rd;
        logic        e_we;
        logic [31:0] e_wd;
        logic        e_err;
    } vec_t;

    obs_t        exp_q[$];
    logic [31:0] obs_rsp_data, obs_wdata, obs_redir_pc;
    logic        obs_we, obs_err;

    function automatic obs_t sample();
        obs_t s;
        s.ready = req_ready;  s.we = csr_we;   s.aw = csr_addr_w; s.ar = csr_addr_r;
        s.wd    = csr_wdata;  s.rv = rsp_valid; s.rd = rsp_data;  s.re = rsp_err;
        s.dv    = redir_valid; s.dpc = redir_pc;
        return s;
    endfunction

    function automatic obs_t idle_rec();
        obs_t r = '0;
        r.ready = 1'b1;
        return r;
    endfunction

    task automatic check_rec(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got rdy=%0b we=%0b aw=%h ar=%h wd=%h rv=%0b rd=%h re=%0b dv=%0b dpc=%h | want rdy=%0b we=%0b aw=%h ar=%h wd=%h rv=%0b rd=%h re=%0b dv=%0b dpc=%h",
                     name, got.ready, got.we, got.aw, got.ar, got.wd, got.rv, got.rd, got.re, got.dv, got.dpc,
                     exp.ready, exp.we, exp.aw, exp.ar, exp.wd, exp.rv, exp.rd, exp.re, exp.dv, exp.dpc);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic preset(input logic [11:0] a, input logic [31:0] v);
        mem[a]   = v;
        model[a] = v;
    endtask

    // Per-cycle expectations derived from the architectural effect of each instruction.
    task automatic predict(input logic [2:0] op, input logic [11:0] a,
                           input logic [31:0] opnd, input logic [31:0] pc);
        obs_t        r;
        logic [31:0] s, ns, v, old, nv;
        exp_q.delete();
        if (op == 3'b000) begin
            r = '0; r.we = 1'b1; r.aw = 12'h341; r.wd = pc; exp_q.push_back(r); model[12'h341] = pc;
            r = '0; r.we = 1'b1; r.aw = 12'h342; r.wd = 32'd11; exp_q.push_back(r); model[12'h342] = 32'd11;
            s  = model[12'h300];
            ns = (s & ~32'h88) | (((s >> 3) & 32'h1) << 7) | 32'h1800;
            r = '0; r.ar = 12'h300; r.we = 1'b1; r.aw = 12'h300; r.wd = ns; exp_q.push_back(r);
            model[12'h300] = ns;
            r = '0; r.dv = 1'b1; r.dpc = model[12'h305] & ~32'h3; exp_q.push_back(r);
        end else if (op == 3'b100) begin
            s  = model[12'h300];
            ns = (s & ~32'h88) | (((s >> 7) & 32'h1) << 3) | 32'h80 | 32'h1800;
            r = '0; r.ar = 12'h300; r.we = 1'b1; r.aw = 12'h300; r.wd = ns; exp_q.push_back(r);
            model[12'h300] = ns;
            r = '0; r.dv = 1'b1; r.dpc = model[12'h341]; exp_q.push_back(r);
        end else begin
            v = op[2] ? (opnd & 32'h1f) : opnd;
            r = '0; r.ar = a; exp_q.push_back(r);
            r = '0; r.rv = 1'b1;
            if (a >= 12'd900) begin
                r.re = 1'b1;
            end else begin
                old  = model[a];
                r.rd = old;
                case (op[1:0])
                    2'b01:   nv = v;
                    2'b10:   nv = old | v;
                    default: nv = old & ~v;
                endcase
                if (op[1:0] == 2'b01 || v != 0) begin
                    r.we = 1'b1; r.aw = a; r.wd = nv; model[a] = nv;
                end
            end
            exp_q.push_back(r);
        end
    endtask

    // Entered and left at posedge+1; the environment applies observed CSR writes to mem.
    task automatic run_op(input logic [2:0] op, input logic [11:0] a, input logic [31:0] opnd,
                          input logic [31:0] pc, input bit noise, input string name);
        obs_t got;
        predict(op, a, opnd, pc);
        obs_rsp_data = '0; obs_wdata = '0; obs_redir_pc = '0; obs_we = 1'b0; obs_err = 1'b0;
        req_valid = 1'b1; req_op = op; req_addr = a; req_operand = opnd; req_pc = pc;
        @(negedge clk);
        check_rec({name, "_idle"}, sample(), idle_rec());
        @(posedge clk); #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (noise) begin
                req_valid   = 1'($urandom_range(0, 1));
                req_op      = 3'($urandom_range(0, 7));
                req_addr    = 12'($urandom);
                req_operand = $urandom;
                req_pc      = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            got = sample();
            check_rec($sformatf("%s_cyc%0d", name, i), got, exp_q[i]);
            if (got.rv) begin
                obs_rsp_data = got.rd; obs_we = got.we; obs_wdata = got.wd; obs_err = got.re;
            end
            if (got.dv) obs_redir_pc = got.dpc;
            @(posedge clk); #1;
            if (got.we) mem[got.aw] = got.wd;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic [2:0]  rop;
        logic [11:0] raddr;
        logic [31:0] ropnd;
        vecs[0] = '{3'b001, 12'h305, 32'h0000_0200, 32'h0000_0170, 32'h0000_0170, 1'b1, 32'h0000_0200, 1'b0};
        vecs[1] = '{3'b010, 12'h300, 32'h0000_0000, 32'h0000_1800, 32'h0000_1800, 1'b0, 32'h0000_0000, 1'b0};
        vecs[2] = '{3'b111, 12'h300, 32'hFFFF_FFE8, 32'h0000_1808, 32'h0000_1808, 1'b1, 32'h0000_1800, 1'b0};
        vecs[3] = '{3'b001, 12'h384, 32'h0000_0055, 32'h0000_ABCD, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[4] = '{3'b110, 12'h340, 32'h0000_0013, 32'h0000_0100, 32'h0000_0100, 1'b1, 32'h0000_0113, 1'b0};
        vecs[5] = '{3'b011, 12'h340, 32'h0000_F0F0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'h0000_0F0F, 1'b0};
        vecs[6] = '{3'b101, 12'h383, 32'h0000_003F, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_001F, 1'b0};
        vecs[7] = '{3'b111, 12'h340, 32'h0000_0020, 32'h0000_0777, 32'h0000_0777, 1'b0, 32'h0000_0000, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_addr = '0; req_operand = '0; req_pc = '0;
        for (int i = 0; i < 4096; i++) preset(12'(i), $urandom);
        @(posedge clk); #1;
        check_rec("reset", sample(), idle_rec());
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            preset(vecs[i].addr, vecs[i].init);
            run_op(vecs[i].op, vecs[i].addr, vecs[i].operand, 32'h0, 1'b0, $sformatf("vec%0d", i));
            check_val($sformatf("vec%0d_rsp_data", i), obs_rsp_data, vecs[i].e_rd);
            check_val($sformatf("vec%0d_we", i), 32'(obs_we), 32'(vecs[i].e_we));
            check_val($sformatf("vec%0d_wdata", i), obs_wdata, vecs[i].e_wd);
            check_val($sformatf("vec%0d_err", i), 32'(obs_err), 32'(vecs[i].e_err));
        end

        preset(12'h300, 32'h1808);
        preset(12'h305, 32'h0171);
        run_op(3'b000, 12'h0, 32'h0, 32'h1000, 1'b0, "ecall");
        check_val("ecall_mepc", mem[12'h341], 32'h1000);
        check_val("ecall_mcause", mem[12'h342], 32'd11);
        check_val("ecall_mstatus", mem[12'h300], 32'h1880);
        check_val("ecall_redir", obs_redir_pc, 32'h0170);

        preset(12'h341, 32'h1004);
        run_op(3'b100, 12'h0, 32'h0, 32'h0, 1'b0, "mret");
        check_val("mret_mstatus", mem[12'h300], 32'h1888);
        check_val("mret_redir", obs_redir_pc, 32'h1004);

        // ECALL aborted by reset while the mcause write is on the bus.
        preset(12'h342, 32'hDEAD);
        preset(12'h300, 32'h1808);
        req_valid = 1'b1; req_op = 3'b000; req_pc = 32'h2000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        begin
            obs_t e = '0;
            e.we = 1'b1; e.aw = 12'h341; e.wd = 32'h2000;
            @(negedge clk);
            check_rec("abort_epc", sample(), e);
        end
        @(posedge clk); #1;
        mem[12'h341] = 32'h2000; model[12'h341] = 32'h2000;
        rst = 1'b1;
        #1;
        check_rec("abort_immediate", sample(), idle_rec());
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_rec($sformatf("abort_quiet%0d", i), sample(), idle_rec());
        end
        @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       raddr = 12'h300;
                1:       raddr = 12'h305;
                2:       raddr = 12'h341;
                3:       raddr = 12'h340;
                4:       raddr = 12'($urandom_range(0, 899));
                default: raddr = 12'($urandom_range(900, 4095));
            endcase
            ropnd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            run_op(rop, raddr, ropnd, $urandom, 1'b1, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
